hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage MIPS pipeline.
- Detects load-use and branch-operand hazards and generates PC/IF-ID stalls and ID/EX bubbles.
- Generates branch/jump redirect and IF/ID flush.
- Freezes the whole pipeline while the data memory handshake is outstanding, and keeps saturating stall/flush statistics counters.

Parameters:
- TIMEOUT, 16, max consecutive cycles waiting on dmem_ack before entering ERR.
- CW, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_branch  in  1  ID holds beq/bne (compared in ID).
- id_branch_taken  in  1  ID branch condition true.
- id_jump  in  1  ID holds j.
- ex_memread  in  1  EX instruction is a load.
- ex_regwrite  in  1  EX instruction writes a register.
- ex_rd  in  5  EX destination register (after RegDst mux).
- mem_memread  in  1  MEM instruction is a load.
- mem_rd  in  5  MEM destination register.
- dmem_req  in  1  MEM stage issuing a data-memory access.
- dmem_ack  in  1  data memory completes the access this cycle.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  zero IF/ID on next edge.
- idex_bubble  out  1  load NOP control into ID/EX.
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB.
- pcsrc_sel  out  1  select branch/jump target into PC mux.
- mem_err  out  1  sticky timeout error.
- stall_cnt  out  CW  cycles with pc_stall=1, saturating.
- flush_cnt  out  CW  cycles with ifid_flush=1, saturating.

Behaviour:
- **Matching rule.** match(r) = (r!=0) & ((id_uses_rs & r==id_rs) | (id_uses_rt & r==id_rt)). Register 0 never creates a hazard.
- **Load-use.** lu = ex_memread & match(ex_rd).
- **Branch hazard.** bh = id_is_branch & ((ex_regwrite & match(ex_rd)) | (mem_memread & match(mem_rd))).
  - A branch depending on an EX-stage load therefore stalls 2 cycles.
  - A branch depending on an EX ALU op or a MEM load stalls 1 cycle.
- **Hazard.** hz = lu | bh.
- **FSM states** RUN, WAIT, ERR; 2-bit state register; wait_cnt is $clog2(TIMEOUT+1) bits.
  - RUN: dmem_req & ~dmem_ack -> WAIT, wait_cnt=1. Otherwise stay.
  - WAIT: dmem_ack -> RUN, wait_cnt=0. Else if wait_cnt==TIMEOUT -> ERR. Else wait_cnt+1.
  - ERR: absorbing until reset; mem_err=1.
- **freeze** = (RUN & dmem_req & ~dmem_ack) | (WAIT & ~dmem_ack) | ERR. All outputs below are combinational from inputs and state.
- **pipe_freeze** = freeze.
- **pc_stall** = freeze | hz.
- **ifid_stall** = freeze | hz.
- **idex_bubble** = ~freeze & hz.
- **redirect** = ~freeze & ~hz & ((id_is_branch & id_branch_taken) | id_jump).
- **pcsrc_sel** = redirect.
- **ifid_flush** = redirect.
- **Stall over redirect.** A taken branch with a hazard produces no redirect until the hazard clears; the branch is held in ID, so the redirect fires later exactly once.
- **Freeze over everything.** During freeze the ID instruction is held; a pending redirect or bubble is suppressed and re-evaluated on the first unfrozen cycle.
- **Single-cycle access.** dmem_req with dmem_ack in the same cycle causes no freeze.
- **Counters** update on the rising edge: stall_cnt += pc_stall, flush_cnt += ifid_flush; each holds at all-ones (no wrap).
- **Reset (async, rst_n=0):**
  - state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0.
  - All combinational outputs 0 if inputs are idle.
  - Reset mid-WAIT returns to RUN immediately.
- **Release** is synchronous on the first edge with rst_n=1.

Test Plan:
- lw $2 in EX (ex_memread=1, ex_rd=2), ID add reads rs=2 -> exactly 1 cycle of pc_stall=ifid_stall=idex_bubble=1; stall_cnt=1. Same case with ex_rd=0 -> no stall.
- beq in ID reading $3:
  - lw $3 in EX -> 2 stall cycles, then pcsrc_sel=ifid_flush=1 for 1 cycle when taken; flush_cnt=1.
  - add $3 in EX -> 1 stall cycle.
- j in ID with id_uses_rs=id_uses_rt=0 and a load to $5 in EX -> no stall, immediate redirect and flush.
- dmem_req=1 with dmem_ack after 3 cycles, taken branch held in ID:
  - pipe_freeze=1 for 3 cycles, pcsrc_sel=0 throughout.
  - Redirect fires in the ack cycle.
  - stall_cnt=3.
- TIMEOUT=4, dmem_ack never asserted -> ERR entered after wait_cnt reaches 4; mem_err=1 and freeze permanent. Deassert rst_n mid-ERR -> all counters and flags 0, state RUN.
- CW=4: 20 consecutive stall cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline: load-use and
// branch-operand stalls, branch/jump redirect, data-memory freeze and statistics.
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic          id_is_branch,
  input  logic          id_branch_taken,
  input  logic          id_jump,
  input  logic          ex_memread,
  input  logic          ex_regwrite,
  input  logic [4:0]    ex_rd,
  input  logic          mem_memread,
  input  logic [4:0]    mem_rd,
  input  logic          dmem_req,
  input  logic          dmem_ack,
  output logic          pc_stall,
  output logic          ifid_stall,
  output logic          ifid_flush,
  output logic          idex_bubble,
  output logic          pipe_freeze,
  output logic          pcsrc_sel,
  output logic          mem_err,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);

  localparam int            WW     = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO_VAL = WW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [WW-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic [CW-1:0] r_stall_cnt, r_flush_cnt;

  logic w_lu, w_bh, w_hz, w_freeze, w_redirect;

  // Register 0 is hard-wired zero, so a write to it can never feed ID.
  function automatic logic f_match(input logic [4:0] r, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic urs,
                                   input logic urt);
    return (r != 5'd0) && ((urs && (r == rs)) || (urt && (r == rt)));
  endfunction

  function automatic logic [CW-1:0] f_sat_inc(input logic [CW-1:0] v, input logic en);
    return (en && (v != {CW{1'b1}})) ? v + CW'(1) : v;
  endfunction

  assign w_lu = ex_memread && f_match(ex_rd, id_rs, id_rt, id_uses_rs, id_uses_rt);
  // Branches resolve in ID, so an EX ALU result or a MEM load is still too late.
  assign w_bh = id_is_branch &&
                ((ex_regwrite && f_match(ex_rd, id_rs, id_rt, id_uses_rs, id_uses_rt)) ||
                 (mem_memread && f_match(mem_rd, id_rs, id_rt, id_uses_rs, id_uses_rt)));
  assign w_hz = w_lu || w_bh;

  assign w_freeze = ((r_state == S_RUN) && dmem_req && !dmem_ack) ||
                    ((r_state == S_WAIT) && !dmem_ack) ||
                    (r_state == S_ERR);

  assign w_redirect = !w_freeze && !w_hz &&
                      ((id_is_branch && id_branch_taken) || id_jump);

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      S_RUN: begin
        if (dmem_req && !dmem_ack) begin
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = WW'(1);
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          w_state_nxt    = S_RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == TO_VAL) begin
          w_state_nxt = S_ERR;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WW'(1);
        end
      end
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
      default: begin
        w_state_nxt    = S_RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_stall_cnt <= f_sat_inc(r_stall_cnt, pc_stall);
      r_flush_cnt <= f_sat_inc(r_flush_cnt, ifid_flush);
    end
  end

  assign pipe_freeze = w_freeze;
  assign pc_stall    = w_freeze || w_hz;
  assign ifid_stall  = w_freeze || w_hz;
  assign idex_bubble = !w_freeze && w_hz;
  assign pcsrc_sel   = w_redirect;
  assign ifid_flush  = w_redirect;
  assign mem_err     = (r_state == S_ERR);
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: hand-derived per-cycle expectations queued at drive
// time, compared at the falling edge, with saturating counter tracking.
module tb_hazard_ctrl;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CW      = 4;
  localparam int CMAX       = (1 << TB_CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken, id_jump;
  logic ex_memread, ex_regwrite, mem_memread, dmem_req, dmem_ack;
  logic pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, pcsrc_sel, mem_err;
  logic [TB_CW-1:0] stall_cnt, flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int m_stall = 0;
  int m_flush = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(TB_TIMEOUT), .CW(TB_CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken), .id_jump(id_jump),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
    .mem_memread(mem_memread), .mem_rd(mem_rd),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .pcsrc_sel(pcsrc_sel),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // Vector order: pc_stall, ifid_stall, idex_bubble, pipe_freeze, pcsrc_sel, ifid_flush, mem_err
  function automatic logic [6:0] e(input logic ps, input logic bub, input logic frz,
                                   input logic rd, input logic err);
    return {ps, ps, bub, frz, rd, rd, err};
  endfunction

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_is_branch = 1'b0; id_branch_taken = 1'b0; id_jump = 1'b0;
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;
    mem_memread = 1'b0; mem_rd = 5'd0; dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic id_set(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic br, input logic tk, input logic j);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_is_branch = br; id_branch_taken = tk; id_jump = j;
  endtask

  task automatic ex_set(input logic mr, input logic rw, input logic [4:0] rd);
    ex_memread = mr; ex_regwrite = rw; ex_rd = rd;
  endtask

  task automatic mem_set(input logic mr, input logic [4:0] rd);
    mem_memread = mr; mem_rd = rd;
  endtask

  task automatic dm_set(input logic req, input logic ack);
    dmem_req = req; dmem_ack = ack;
  endtask

  // Inputs are set just after a rising edge; outputs are checked on the falling edge.
  task automatic cyc(input string tag, input logic [6:0] exp);
    logic [6:0] want;
    exp_q.push_back(exp);
    @(negedge clk);
    want = exp_q.pop_front();
    if (!rst_n) begin
      m_stall = 0;
      m_flush = 0;
    end
    chk({tag, ".out"}, 32'({pc_stall, ifid_stall, idex_bubble, pipe_freeze,
                           pcsrc_sel, ifid_flush, mem_err}), 32'(want));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
    if (rst_n) begin
      if (want[6] && m_stall < CMAX) m_stall++;
      if (want[1] && m_flush < CMAX) m_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    cyc("reset", e(0, 0, 0, 0, 0));
    rst_n = 1'b1;
    cyc("release", e(0, 0, 0, 0, 0));

    // Load-use on rs, then on rt, and the non-hazard variants
    id_set(5'd2, 5'd9, 1, 1, 0, 0, 0); ex_set(1, 1, 5'd2);
    cyc("lu_rs", e(1, 1, 0, 0, 0));
    ex_set(0, 0, 5'd0);
    cyc("lu_rs_after", e(0, 0, 0, 0, 0));
    id_set(5'd0, 5'd0, 1, 1, 0, 0, 0); ex_set(1, 1, 5'd0);
    cyc("lu_r0", e(0, 0, 0, 0, 0));
    id_set(5'd1, 5'd7, 1, 1, 0, 0, 0); ex_set(1, 1, 5'd7);
    cyc("lu_rt", e(1, 1, 0, 0, 0));
    id_set(5'd1, 5'd7, 1, 0, 0, 0, 0);
    cyc("lu_rt_unused", e(0, 0, 0, 0, 0));
    id_set(5'd7, 5'd1, 1, 1, 0, 0, 0); ex_set(0, 1, 5'd7);
    cyc("alu_nobranch", e(0, 0, 0, 0, 0));

    // beq reading $3 behind lw $3: two stalls then one redirect
    idle(); id_set(5'd3, 5'd4, 1, 1, 1, 1, 0); ex_set(1, 1, 5'd3);
    cyc("br_lw_s1", e(1, 1, 0, 0, 0));
    ex_set(0, 0, 5'd0); mem_set(1, 5'd3);
    cyc("br_lw_s2", e(1, 1, 0, 0, 0));
    mem_set(0, 5'd0);
    cyc("br_lw_redir", e(0, 0, 0, 1, 0));
    idle();
    cyc("br_lw_done", e(0, 0, 0, 0, 0));

    // beq reading $3 behind add $3: one stall then redirect; not-taken variant
    id_set(5'd4, 5'd3, 1, 1, 1, 1, 0); ex_set(0, 1, 5'd3);
    cyc("br_alu_s1", e(1, 1, 0, 0, 0));
    ex_set(0, 0, 5'd0); mem_set(0, 5'd3);
    cyc("br_alu_redir", e(0, 0, 0, 1, 0));
    id_set(5'd4, 5'd3, 1, 1, 1, 0, 0); mem_set(0, 5'd0);
    cyc("br_not_taken", e(0, 0, 0, 0, 0));

    // Jump ignores register fields it does not read
    idle(); id_set(5'd5, 5'd5, 0, 0, 0, 0, 1); ex_set(1, 1, 5'd5);
    cyc("jump", e(0, 0, 0, 1, 0));

    // Memory wait of 3 cycles with a taken branch held in ID
    idle(); id_set(5'd6, 5'd8, 1, 1, 1, 1, 0); dm_set(1, 0);
    cyc("frz_1", e(1, 0, 1, 0, 0));
    cyc("frz_2", e(1, 0, 1, 0, 0));
    cyc("frz_3", e(1, 0, 1, 0, 0));
    dm_set(1, 1);
    cyc("frz_ack_redir", e(0, 0, 0, 1, 0));
    idle();
    cyc("frz_done", e(0, 0, 0, 0, 0));

    // Bubble suppressed while frozen, reappears on the ack cycle
    id_set(5'd2, 5'd0, 1, 0, 0, 0, 0); ex_set(1, 1, 5'd2); dm_set(1, 0);
    cyc("frz_lu", e(1, 0, 1, 0, 0));
    dm_set(0, 1);
    cyc("frz_lu_ack", e(1, 1, 0, 0, 0));
    idle();
    cyc("frz_lu_done", e(0, 0, 0, 0, 0));

    // Single-cycle access never freezes
    id_set(5'd0, 5'd0, 0, 0, 0, 0, 1); dm_set(1, 1);
    cyc("single_jump", e(0, 0, 0, 1, 0));
    id_set(5'd0, 5'd0, 0, 0, 0, 0, 0);
    cyc("single_idle", e(0, 0, 0, 0, 0));

    // Reset in the middle of a wait returns to RUN
    dm_set(1, 0);
    cyc("rw_run", e(1, 0, 1, 0, 0));
    dm_set(0, 0);
    cyc("rw_wait", e(1, 0, 1, 0, 0));
    rst_n = 1'b0;
    cyc("rw_reset", e(0, 0, 0, 0, 0));
    rst_n = 1'b1;
    cyc("rw_release", e(0, 0, 0, 0, 0));

    // Timeout: RUN cycle plus wait_cnt 1..TIMEOUT, then ERR
    dm_set(1, 0);
    cyc("to_run", e(1, 0, 1, 0, 0));
    for (int i = 1; i <= TB_TIMEOUT; i++) cyc($sformatf("to_wait%0d", i), e(1, 0, 1, 0, 0));
    cyc("to_err", e(1, 0, 1, 0, 1));
    dm_set(0, 1); id_set(5'd0, 5'd0, 0, 0, 0, 0, 1);
    cyc("err_sticky_ack", e(1, 0, 1, 0, 1));
    idle();
    cyc("err_sticky_idle", e(1, 0, 1, 0, 1));
    rst_n = 1'b0;
    cyc("err_reset", e(0, 0, 0, 0, 0));
    rst_n = 1'b1;
    cyc("err_release", e(0, 0, 0, 0, 0));

    // Counter saturation over 20 consecutive stalls
    id_set(5'd2, 5'd0, 1, 0, 0, 0, 0); ex_set(1, 1, 5'd2);
    for (int i = 0; i < 20; i++) cyc($sformatf("sat%0d", i), e(1, 1, 0, 0, 0));
    idle();
    cyc("sat_idle", e(0, 0, 0, 0, 0));
    chk("sat_final", 32'(stall_cnt), 32'(CMAX));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
